// File: rtl/cpu_run_controller_pkg.sv
// cpu_ctrl_pkg: shared types for the CPU run/step controller.
//   cmd_op_t    - command encodings (RUN, STEP, HALT, CLEAR)
//   run_state_t - controller FSM states (IDLE, RUN, STALL, DONE)
//   snapshot_t  - one captured FIFO entry {cycle index, debug word}
// The snapshot fields are sized for the widest supported configuration.
// Narrower controller instances zero-extend on push and truncate on read.
package cpu_ctrl_pkg;

  localparam int SNAP_CYCLE_W = 16;
  localparam int SNAP_DATA_W  = 32;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_STEP  = 2'd1,
    OP_HALT  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  typedef struct packed {
    logic [SNAP_CYCLE_W-1:0] cycle;
    logic [SNAP_DATA_W-1:0]  data;
  } snapshot_t;

  // True in the states where a new RUN/STEP/CLEAR may be accepted.
  function automatic logic is_quiescent(run_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: groups the command, CPU and snapshot signals of the
// run controller.
//   master modport - host/bench side (drives commands, debug word, snap_ready)
//   slave modport  - controller side
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid && ready are both high. The sender holds its payload stable
// while valid is high and ready is low; nothing is dropped.
//   command channel : cmd_valid / cmd_ready, payload cmd_op, cmd_count
//   snapshot channel: snap_valid / snap_ready, payload snap_data, snap_cycle
interface cpu_run_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [CNT_WIDTH-1:0]  cmd_count;
  logic                  cpu_en;
  logic [DATA_WIDTH-1:0] debug_in;
  logic                  snap_valid;
  logic                  snap_ready;
  logic [DATA_WIDTH-1:0] snap_data;
  logic [CNT_WIDTH-1:0]  snap_cycle;
  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic                  done;

  modport master (
    output cmd_valid, cmd_op, cmd_count, debug_in, snap_ready,
    input  cmd_ready, cpu_en, snap_valid, snap_data, snap_cycle,
           state, cycle_count, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, debug_in, snap_ready,
    output cmd_ready, cpu_en, snap_valid, snap_data, snap_cycle,
           state, cycle_count, done
  );
endinterface

// File: rtl/cpu_run_controller_snapshot_fifo.sv
// snapshot_fifo: synchronous first-word-fall-through FIFO of snapshot_t.
//   clk, rst_n - clock, synchronous active-low reset (empties the FIFO)
//   push_i     - write wdata_i (ignored when full)
//   pop_i      - drop the head entry (ignored when empty)
//   flush_i    - empty the FIFO on this edge (wins over push/pop)
//   wdata_i    - entry to write
//   rdata_o    - head entry, valid whenever empty_o is low
//   full_o, empty_o, count_o - occupancy status
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module snapshot_fifo
  import cpu_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  snapshot_t                wdata_i,
  output snapshot_t                rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  snapshot_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says valid.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/step controller for CPU bring-up.
// Gates the core with cpu_en, runs it for a commanded number of cycles and
// captures {cycle_count, debug_in} into a snapshot FIFO on every enabled edge.
//   clk, rst_n      - clock, synchronous active-low reset
//   bus (slave)     - command channel (cmd_valid/cmd_ready/cmd_op/cmd_count),
//                     CPU side (cpu_en, debug_in), snapshot channel
//                     (snap_valid/snap_ready/snap_data/snap_cycle) and status
//                     (state, cycle_count, done)
// Parameters: MAX_CYCLES (run length for cmd_count==0), DATA_WIDTH,
// CNT_WIDTH, FIFO_DEPTH (power of two >= 2).
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cpu_run_controller_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);

  run_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic                  done_q, done_d;
  logic                  flush;

  cmd_op_t               op;
  logic                  quiescent;
  logic                  cmd_ready;
  logic                  accept;
  logic                  cpu_en;
  logic                  pop;
  logic                  fills;
  logic [CNT_WIDTH-1:0]  run_len;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PW:0]           fifo_count;
  snapshot_t             fifo_wdata;
  snapshot_t             fifo_head;

  assign op        = cmd_op_t'(bus.cmd_op);
  assign quiescent = is_quiescent(state_q);

  // Outputs that start activity are forced low while reset is asserted, so
  // nothing moves on the reset edge even though state is still old.
  assign cmd_ready = rst_n && (quiescent || (op == OP_HALT));
  assign accept    = bus.cmd_valid && cmd_ready;
  assign cpu_en    = rst_n && (state_q == ST_RUN) && !fifo_full;
  assign pop       = bus.snap_valid && bus.snap_ready;

  // This push takes the last free slot (no pop frees one in the same edge).
  assign fills = cpu_en && !pop && (fifo_count == (PW+1)'(FIFO_DEPTH - 1));

  assign run_len = (bus.cmd_count == '0) ? CNT_WIDTH'(MAX_CYCLES) : bus.cmd_count;

  assign fifo_wdata.cycle = SNAP_CYCLE_W'(cycle_q);
  assign fifo_wdata.data  = SNAP_DATA_W'(bus.debug_in);

  snapshot_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cpu_en),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cycle_q     <= cycle_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cycle_d     = cycle_q;
    done_d      = 1'b0;
    flush       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (cpu_en) begin
          cycle_d     = cycle_q + CNT_WIDTH'(1);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (fills) begin
            state_d = ST_STALL;
          end
        end else if (!pop) begin
          // Entered RUN with a FIFO left full by an earlier run. A pop here
          // leaves us in RUN but cannot also push on this edge.
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (pop) state_d = ST_RUN;
      end
      default: ;
    endcase

    // Commands override the run progress above. An enabled edge that
    // coincides with HALT still executes; only the continuation is cut.
    if (accept) begin
      case (op)
        OP_RUN: begin
          remaining_d = run_len;
          state_d     = ST_RUN;
        end
        OP_STEP: begin
          remaining_d = CNT_WIDTH'(1);
          state_d     = ST_RUN;
        end
        OP_HALT: begin
          if (!quiescent) begin
            remaining_d = '0;
            state_d     = ST_IDLE;
            done_d      = 1'b0;
          end
        end
        OP_CLEAR: begin
          flush   = 1'b1;
          cycle_d = '0;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.cpu_en      = cpu_en;
  assign bus.snap_valid  = rst_n && !fifo_empty;
  assign bus.snap_data   = DATA_WIDTH'(fifo_head.data);
  assign bus.snap_cycle  = CNT_WIDTH'(fifo_head.cycle);
  assign bus.state       = state_q;
  assign bus.cycle_count = cycle_q;
  assign bus.done        = done_q;

endmodule
